cfg_loader: RTL and testbench

CFG_LOADER -- requirements
Module: cfg_loader

---
 rtl/cfg_loader.sv | 183 ++++++++++++++++++
 tb/tb_cfg_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_loader.sv
// Configuration loader: queues host commands and serialises them as one-cycle
// config frames onto the PE chain, with guard gaps after SWITCH/START.
module cfg_loader #(
    parameter int INST_WIDTH = 64,
    parameter int ID         = 2,
    parameter int INST_WORD  = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CHAIN_LEN  = 4,
    localparam int CONF      = INST_WIDTH + ID + 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ID-1:0]         cmd_id,
    input  logic [INST_WIDTH-1:0] cmd_data,
    output logic [CONF-1:0]       pe_config_out,
    output logic                  busy,
    output logic                  err_overflow
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int EW      = 2 + ID + INST_WIDTH;
    localparam int NUM_IDS = 1 << ID;
    localparam int CW      = $clog2(INST_WORD) + 1;
    localparam int GW      = $clog2(CHAIN_LEN + 1);

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_SWITCH = 2'b01;
    localparam logic [1:0] OP_START  = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        GUARD = 1'b1
    } state_t;

    state_t state_reg, state_next;
    logic [GW-1:0] guard_reg, guard_next;

    logic [EW-1:0]         fifo_mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_reg, rd_ptr_reg;
    logic                  fifo_full, fifo_empty;
    logic                  push, pop;
    logic [1:0]            head_op;
    logic [ID-1:0]         head_id;
    logic [INST_WIDTH-1:0] head_data;

    logic [CW-1:0]         wcnt [NUM_IDS];
    logic [NUM_IDS-1:0]    wcnt_inc;
    logic                  wcnt_clear;
    logic                  at_limit;

    logic [CONF-1:0]       frame_next;
    logic                  ovf_set;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign pop        = (state_reg == IDLE) && !fifo_empty;
    assign busy       = !fifo_empty || (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= {cmd_op, cmd_id, cmd_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

    // Head is read combinationally so a fresh command issues the cycle after it lands.
    assign {head_op, head_id, head_data} = fifo_mem[rd_ptr_reg[AW-1:0]];

    generate
        for (genvar gi = 0; gi < NUM_IDS; gi++) begin : g_wcnt
            logic [CW-1:0] cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (wcnt_clear) begin
                    cnt_reg <= '0;
                end else if (wcnt_inc[gi]) begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end

            assign wcnt[gi] = cnt_reg;
        end
    endgenerate

    assign at_limit = (wcnt[head_id] == CW'(INST_WORD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            guard_reg <= '0;
        end else begin
            state_reg <= state_next;
            guard_reg <= guard_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        guard_next = guard_reg;
        case (state_reg)
            IDLE: begin
                if (pop && (head_op == OP_SWITCH || head_op == OP_START)) begin
                    state_next = GUARD;
                    guard_next = GW'(CHAIN_LEN);
                end
            end
            GUARD: begin
                guard_next = guard_reg - GW'(1);
                if (guard_reg == GW'(1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                guard_next = '0;
            end
        endcase
    end

    // Frame layout, MSB first: {inst, id, valid, w_switch, r_switch, start}.
    always_comb begin
        frame_next = '0;
        wcnt_inc   = '0;
        wcnt_clear = 1'b0;
        ovf_set    = 1'b0;
        if (pop) begin
            case (head_op)
                OP_WRITE: begin
                    if (at_limit) begin
                        ovf_set = 1'b1;
                    end else begin
                        frame_next        = {head_data, head_id, 4'b1000};
                        wcnt_inc[head_id] = 1'b1;
                    end
                end
                OP_SWITCH: begin
                    frame_next[2] = head_data[0];
                    frame_next[1] = head_data[1];
                    wcnt_clear    = head_data[0];
                end
                OP_START: begin
                    frame_next[0] = 1'b1;
                end
                default: begin
                    frame_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_config_out <= '0;
            err_overflow  <= 1'b0;
        end else begin
            pe_config_out <= frame_next;
            err_overflow  <= err_overflow | ovf_set;
        end
    end

endmodule

// File: tb/tb_cfg_loader.sv
// Directed bench for cfg_loader: issue order, latency, guard gaps, overflow,
// FIFO back-pressure and reset flushing.
module tb_cfg_loader;

    localparam int IW    = 64;
    localparam int IDW   = 2;
    localparam int CONF  = IW + IDW + 4;

    localparam logic [1:0] OP_W  = 2'b00;
    localparam logic [1:0] OP_SW = 2'b01;
    localparam logic [1:0] OP_ST = 2'b10;
    localparam logic [1:0] OP_RS = 2'b11;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [IDW-1:0]  cmd_id;
    logic [IW-1:0]   cmd_data;
    logic [CONF-1:0] pe_config_out;
    logic            busy;
    logic            err_overflow;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    logic [CONF-1:0] mon_frame[$];
    int              mon_cyc[$];

    cfg_loader #(
        .INST_WIDTH(IW),
        .ID(IDW),
        .INST_WORD(32),
        .FIFO_DEPTH(4),
        .CHAIN_LEN(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_id(cmd_id),
        .cmd_data(cmd_data),
        .pe_config_out(pe_config_out),
        .busy(busy),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every non-zero frame is logged with the cycle it was visible in.
    always @(negedge clk) begin
        if (rst_n && pe_config_out != '0) begin
            mon_frame.push_back(pe_config_out);
            mon_cyc.push_back(cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CONF-1:0] fw(input logic [IW-1:0] d, input logic [IDW-1:0] id);
        return {d, id, 4'b1000};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] op, input logic [IDW-1:0] id, input logic [IW-1:0] data);
        $display("push cyc=%0d op=%0d id=%0d data=%0h ready=%0b", cyc, op, id, data, cmd_ready);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_id    = id;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic mon_clear();
        mon_frame.delete();
        mon_cyc.delete();
    endtask

    task automatic expect_frame(input string tag, input int i, input logic [CONF-1:0] f, input int c);
        if (i < mon_frame.size()) begin
            check($sformatf("%s_frame", tag), 128'(mon_frame[i]), 128'(f));
            check($sformatf("%s_cycle", tag), 128'(mon_cyc[i]), 128'(c));
        end else begin
            check($sformatf("%s_missing", tag), 128'(mon_frame.size()), 128'(i + 1));
        end
    endtask

    int c0;
    int idx;
    int acc_cyc [5];
    logic rdy;
    logic rdy_hist [20];

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_id    = '0;
        cmd_data  = '0;
        repeat (3) tick();
        check("rst_ready", 128'(cmd_ready), 128'(1));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_out", 128'(pe_config_out), 128'(0));
        rst_n = 1'b1;
        tick();
        check("rel_ready", 128'(cmd_ready), 128'(1));
        check("rel_busy", 128'(busy), 128'(0));
        check("rel_err", 128'(err_overflow), 128'(0));

        // Three back-to-back writes: frames two cycles after each accept.
        mon_clear();
        c0 = cyc;
        push(OP_W, 2'd1, 64'hA);
        push(OP_W, 2'd1, 64'hB);
        push(OP_W, 2'd1, 64'hC);
        tick();
        tick();
        check("s1_busy", 128'(busy), 128'(0));
        check("s1_zero", 128'(pe_config_out), 128'(0));
        check("s1_count", 128'(mon_frame.size()), 128'(3));
        expect_frame("s1_a", 0, fw(64'hA, 2'd1), c0 + 2);
        expect_frame("s1_b", 1, fw(64'hB, 2'd1), c0 + 3);
        expect_frame("s1_c", 2, fw(64'hC, 2'd1), c0 + 4);

        // SWITCH(w) then WRITE: write lands five cycles after the switch pulse.
        mon_clear();
        c0 = cyc;
        push(OP_SW, 2'd0, 64'h1);
        push(OP_W, 2'd2, 64'h55);
        tick();
        tick();
        check("s2_busy_guard", 128'(busy), 128'(1));
        repeat (6) tick();
        check("s2_count", 128'(mon_frame.size()), 128'(2));
        expect_frame("s2_sw", 0, CONF'(4'b0100), c0 + 2);
        expect_frame("s2_wr", 1, fw(64'h55, 2'd2), c0 + 7);

        // 33 writes to one PE: the last overflows the 32-entry imem.
        mon_clear();
        c0 = cyc;
        for (int i = 0; i < 33; i++) begin
            push(OP_W, 2'd0, 64'h1000 + 64'(i));
        end
        check("s3_err_before", 128'(err_overflow), 128'(0));
        tick();
        check("s3_err_set", 128'(err_overflow), 128'(1));
        check("s3_drop_zero", 128'(pe_config_out), 128'(0));
        tick();
        tick();
        check("s3_count", 128'(mon_frame.size()), 128'(32));
        for (int i = 0; i < 32; i++) begin
            expect_frame($sformatf("s3_w%0d", i), i, fw(64'h1000 + 64'(i), 2'd0), c0 + 2 + i);
        end

        // r_switch alone keeps counters; w_switch clears them.
        mon_clear();
        c0 = cyc;
        push(OP_SW, 2'd0, 64'h2);
        push(OP_W, 2'd0, 64'h77);
        push(OP_SW, 2'd0, 64'h3);
        push(OP_W, 2'd0, 64'h88);
        repeat (10) tick();
        check("s3b_count", 128'(mon_frame.size()), 128'(3));
        expect_frame("s3b_rsw", 0, CONF'(4'b0010), c0 + 2);
        expect_frame("s3b_wrsw", 1, CONF'(4'b0110), c0 + 8);
        expect_frame("s3b_wr", 2, fw(64'h88, 2'd0), c0 + 13);
        check("s3b_err_sticky", 128'(err_overflow), 128'(1));

        // Fill the FIFO while the START guard stalls issue.
        mon_clear();
        c0 = cyc;
        push(OP_ST, 2'd0, 64'h0);
        idx = 0;
        for (int k = 0; k < 20; k++) begin
            rdy_hist[k] = 1'b0;
        end
        for (int k = 0; k < 20 && idx < 5; k++) begin
            cmd_valid   = 1'b1;
            cmd_op      = OP_W;
            cmd_id      = 2'd3;
            cmd_data    = 64'h200 + 64'(idx);
            rdy         = cmd_ready;
            rdy_hist[k] = rdy;
            tick();
            if (rdy) begin
                acc_cyc[idx] = cyc - 1;
                $display("accept cyc=%0d idx=%0d data=%0h", cyc - 1, idx, 64'h200 + 64'(idx));
                idx++;
            end
        end
        cmd_valid = 1'b0;
        check("s4_accepts", 128'(idx), 128'(5));
        check("s4_ready_full0", 128'(rdy_hist[4]), 128'(0));
        check("s4_ready_full_pop", 128'(rdy_hist[5]), 128'(0));
        check("s4_ready_again", 128'(rdy_hist[6]), 128'(1));
        check("s4_acc4_cyc", 128'(acc_cyc[3]), 128'(c0 + 4));
        check("s4_acc5_cyc", 128'(acc_cyc[4]), 128'(c0 + 7));
        repeat (6) tick();
        check("s4_count", 128'(mon_frame.size()), 128'(6));
        expect_frame("s4_start", 0, CONF'(1), c0 + 2);
        for (int i = 0; i < 5; i++) begin
            expect_frame($sformatf("s4_w%0d", i), i + 1, fw(64'h200 + 64'(i), 2'd3), c0 + 7 + i);
        end

        // START, reserved, START: CHAIN_LEN+1 zero frames between the pulses.
        mon_clear();
        c0 = cyc;
        push(OP_ST, 2'd0, 64'h0);
        push(OP_RS, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF);
        push(OP_ST, 2'd0, 64'h0);
        repeat (7) tick();
        check("s5_count", 128'(mon_frame.size()), 128'(2));
        expect_frame("s5_st1", 0, CONF'(1), c0 + 2);
        expect_frame("s5_st2", 1, CONF'(1), c0 + 8);
        check("s5_err_sticky", 128'(err_overflow), 128'(1));

        // Reset mid-guard with two writes queued.
        c0 = cyc;
        push(OP_ST, 2'd0, 64'h0);
        push(OP_W, 2'd1, 64'h31);
        push(OP_W, 2'd1, 64'h32);
        check("s6_busy_pre", 128'(busy), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_out", 128'(pe_config_out), 128'(0));
        check("s6_busy", 128'(busy), 128'(0));
        check("s6_ready", 128'(cmd_ready), 128'(1));
        check("s6_err_clr", 128'(err_overflow), 128'(0));
        tick();
        rst_n = 1'b1;
        mon_clear();
        repeat (10) tick();
        check("s6_no_frames", 128'(mon_frame.size()), 128'(0));
        check("s6_busy_after", 128'(busy), 128'(0));

        // Reset while a frame is on the output clears it at once.
        c0 = cyc;
        push(OP_ST, 2'd0, 64'h0);
        push(OP_W, 2'd2, 64'h41);
        push(OP_W, 2'd2, 64'h42);
        push(OP_W, 2'd2, 64'h43);
        repeat (3) tick();
        check("s6b_frame", 128'(pe_config_out), 128'(fw(64'h41, 2'd2)));
        #2;
        rst_n = 1'b0;
        #1;
        check("s6b_out", 128'(pe_config_out), 128'(0));
        check("s6b_busy", 128'(busy), 128'(0));
        tick();
        rst_n = 1'b1;
        mon_clear();
        repeat (8) tick();
        check("s6b_no_frames", 128'(mon_frame.size()), 128'(0));

        // Fresh write after reset issues normally and pulses for one cycle.
        push(OP_W, 2'd0, 64'h99);
        tick();
        check("s7_frame", 128'(pe_config_out), 128'(fw(64'h99, 2'd0)));
        tick();
        check("s7_pulse", 128'(pe_config_out), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
